seq_match_logger: RTL
=====================

// Module: seq_match_logger
// PURPOSE
//  Downstream consumer of the serial sequence detector's one-bit match output.
//  Timestamps every match with the bit index at which it fired and queues the timestamp in a small FIFO.
//  A host reads the FIFO over a valid/ready port.
//  Also keeps a saturating match counter and a sticky overflow flag for status readback.
// PARAMETERS
//  IDX_W   16  width of free-running bit-index counter / stored timestamp
//  DEPTH   4   FIFO entries; power of 2, >= 2
//  CNT_W   8   width of saturating match counter
// PORTS
//  clk        in   1      rising-edge clock, same clock as detector (one input bit per cycle)
//  rst        in   1      synchronous, active-high reset
//  det_in     in   1      match strobe from detector (Mealy, combinational); sampled at clk edge
//  clr        in   1      synchronous flush of FIFO, counter and overflow; bit index unaffected
//  evt_valid  out  1      FIFO non-empty; evt_index is valid
//  evt_ready  in   1      host accepts head entry when evt_valid && evt_ready
//  evt_index  out  IDX_W  bit index of oldest queued match
//  match_cnt  out  CNT_W  total matches seen since rst/clr, saturating
//  overflow   out  1      sticky: a match was dropped because FIFO was full
// BEHAVIOUR
//  Reset: rst high at an edge -> bit_idx=0, FIFO empty, evt_valid=0, evt_index=0, match_cnt=0, overflow=0.
//  Bit index:
//   - bit_idx is 0 in the first cycle with rst low; +1 every cycle after.
//   - Wraps modulo 2^IDX_W with no flag.
//   - A match sampled in cycle k stores bit_idx=k.
//  FIFO:
//   - First-word-fall-through; evt_index is driven from the head entry (registered storage).
//   - evt_valid = !empty.
//   - When the FIFO is empty, det_in=1 at edge k makes evt_valid=1 in cycle k+1.
//   - No bypass.
//  Pop: evt_valid && evt_ready at an edge removes the head. evt_ready while empty is ignored.
//  Push: det_in at an edge is accepted if !full || pop in the same cycle.
//  Full and no pop: the entry is dropped and overflow is set. The existing contents stay unchanged.
//  Simultaneous push+pop:
//   - When full: both occur and occupancy is unchanged.
//   - When occupancy is 1: the new entry becomes head next cycle.
//  Occupancy: tracked with log2(DEPTH)+1-bit pointers; full/empty are derived from the pointer MSB compare.
//  match_cnt:
//   - +1 on every det_in=1, including dropped matches.
//   - Holds at 2^CNT_W-1.
//  clr (priority below rst, above all else):
//   - Empties FIFO; zeros match_cnt and overflow.
//   - det_in in the same cycle is discarded and not counted.
//   - bit_idx keeps counting.
//  rst mid-operation: all state is lost, including queued entries. Any pending handshake is abandoned.
//  No X on outputs after the first reset edge. det_in/evt_ready X while rst=1 are don't-care.
// TESTING
//  1 Basic: rst 2 cycles; det_in=1 in cycles 6 and 12; evt_ready=1 -> evt_valid high in cycles 7 and 13 only; evt_index=6 then 12; match_cnt=2; overflow=0.
//  2 Overflow (DEPTH=4): evt_ready=0; det_in at 3,5,7,9,11,13 -> evt_valid from cycle 4; overflow=1 from cycle 12; match_cnt=6; then evt_ready=1 drains 3,5,7,9 and evt_valid falls after 4 pops.
//  3 Full + pop same edge: fill 4 entries (1,2,3,4); in cycle 8 det_in=1 and evt_ready=1 -> head becomes 2, the 8 entry is queued last, overflow stays 0, occupancy 4.
//  4 Wrap (IDX_W=4): det_in in cycle 17 -> evt_index=1; in cycle 15 -> 15.
//  5 Saturation (CNT_W=3): 9 det_in pulses with evt_ready=1 -> match_cnt reads 7 after the 7th pulse and holds at 7.
//  6 clr/rst mid-operation: 3 entries queued, overflow=1; clr and det_in in cycle 20 -> cycle 21: evt_valid=0, match_cnt=0, overflow=0; det_in in cycle 22 gives evt_index=22; rst in cycle 30 then det_in at first post-reset cycle gives evt_index=0.

Source files
------------

// File: rtl/seq_match_logger.sv
// Timestamps detector match strobes with a free-running bit index and queues them
// in a small first-word-fall-through FIFO read over valid/ready; also keeps status counters.
module seq_match_logger #(
  parameter int IDX_W = 16,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             det_in,
  input  logic             clr,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [IDX_W-1:0] evt_index,
  output logic [CNT_W-1:0] match_cnt,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [IDX_W-1:0] bit_idx;
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic [IDX_W-1:0] mem [DEPTH];
  logic             empty;
  logic             full;
  logic             pop;
  logic             push;
  logic             drop;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  // Extra pointer MSB distinguishes full from empty when the address bits match.
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop   = !empty && evt_ready;
  assign push  = det_in && (!full || pop);
  assign drop  = det_in && full && !pop;

  assign evt_valid = !empty;
  // Masking the head while empty keeps the output defined before storage is ever written.
  assign evt_index = empty ? '0 : mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_idx   <= '0;
      wptr      <= '0;
      rptr      <= '0;
      match_cnt <= '0;
      overflow  <= 1'b0;
    end else begin
      bit_idx <= bit_idx + 1'b1;
      if (clr) begin
        rptr      <= wptr;
        match_cnt <= '0;
        overflow  <= 1'b0;
      end else begin
        if (pop)    rptr      <= rptr + 1'b1;
        if (push)   wptr      <= wptr + 1'b1;
        if (det_in) match_cnt <= sat_inc(match_cnt);
        if (drop)   overflow  <= 1'b1;
      end
    end
  end

  // Timestamp storage carries no reset; only entries behind the pointers are ever read.
  always_ff @(posedge clk) begin
    if (!rst && !clr && push) begin
      mem[wptr[AW-1:0]] <= bit_idx;
    end
  end

endmodule
